// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial, LSB-first subtractor computing diff = a - b - bin modulo
//   2^WIDTH. One bit is resolved per clock through a full-subtractor cell.
//   The operands shift right past the cell, and each difference bit enters
//   the result register from the MSB end.
//
// Configuration macro:
//   SERIAL_SUB_OVF_EN  when defined, adds the ovf output and the flops that
//                      hold the operand sign bits needed to compute it.
//
// Ports:
//   clk    in   1      clock, rising edge
//   rst    in   1      asynchronous reset, active-high
//   start  in   1      operation request, accepted only when not busy
//   a      in   WIDTH  minuend, captured on an accepted start
//   b      in   WIDTH  subtrahend, captured on an accepted start
//   bin    in   1      borrow-in, captured on an accepted start
//   busy   out  1      high while bits are being processed
//   done   out  1      one-cycle pulse; diff/bout (ovf) are valid
//   diff   out  WIDTH  result, held until the next completion
//   bout   out  1      final borrow out of the MSB (a < b + bin, unsigned)
//   ovf    out  1      signed overflow (SERIAL_SUB_OVF_EN only)
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  // Only WIDTH-1 partial bits are stored: the final bit goes directly
  // into diff on the edge that completes the operation.
  logic [WIDTH-2:0] res_reg;
  logic             borrow_reg;

  logic             accept;
  logic             last_bit;
  logic             diff_bit;
  logic             borrow_next;
  logic [WIDTH-1:0] res_shift;

`ifdef SERIAL_SUB_OVF_EN
  logic             a_sign_reg;
  logic             b_sign_reg;
`endif

  // Full-subtractor cell acting on the current LSBs.
  always_comb begin
    diff_bit    = a_reg[0] ^ b_reg[0] ^ borrow_reg;
    borrow_next = (~a_reg[0] & b_reg[0]) | (~(a_reg[0] ^ b_reg[0]) & borrow_reg);
    res_shift   = {diff_bit, res_reg};
    last_bit    = (count_reg == LAST_BIT);
    // A start arriving in DONE is accepted as well, so that back-to-back
    // operations need no idle cycle.
    accept      = start && (state_reg != RUN);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and status decode.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        state_next = start ? RUN : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Serial datapath and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg  <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      res_reg    <= '0;
      borrow_reg <= 1'b0;
      diff       <= '0;
      bout       <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_sign_reg <= 1'b0;
      b_sign_reg <= 1'b0;
      ovf        <= 1'b0;
`endif
    end else if (accept) begin
      count_reg  <= '0;
      a_reg      <= a;
      b_reg      <= b;
      borrow_reg <= bin;
`ifdef SERIAL_SUB_OVF_EN
      a_sign_reg <= a[WIDTH-1];
      b_sign_reg <= b[WIDTH-1];
`endif
    end else if (state_reg == RUN) begin
      count_reg  <= count_reg + CW'(1);
      a_reg      <= a_reg >> 1;
      b_reg      <= b_reg >> 1;
      res_reg    <= res_shift[WIDTH-1:1];
      borrow_reg <= borrow_next;
      if (last_bit) begin
        // Outputs change only here, so they stay stable through RUN.
        diff <= res_shift;
        bout <= borrow_next;
`ifdef SERIAL_SUB_OVF_EN
        // Operands of differing sign overflow when the result sign
        // disagrees with the minuend sign.
        ovf  <= (a_sign_reg != b_sign_reg) && (diff_bit != a_sign_reg);
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  logic [W-1:0] last_diff = '0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no end / required end");
    $fatal(1, "watchdog");
  end

  // Reference: unsigned subtraction in W+1 bits; the top bit is the borrow.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                          input logic rbin);
    logic [W:0] r;
    r = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
    return r;
  endfunction

  // Reference signed overflow: operand signs differ and result sign differs from a.
  function automatic logic ref_ovf(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                   input logic [W-1:0] rd);
    return (ra[W-1] != rb[W-1]) && (rd[W-1] != ra[W-1]);
  endfunction

  // Drive a start request; returns #1 after the edge that samples it.
  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin);
    a     = ta;
    b     = tb_v;
    bin   = tbin;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges until done is seen; -1 if the budget runs out.
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 4 * W; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", done); end
    n_cmp++; if (diff !== '0) begin n_fail++; $display("FAIL reset_diff: got %h required 00", diff); end
    n_cmp++; if (bout !== 1'b0) begin n_fail++; $display("FAIL reset_bout: got %b required 0", bout); end
`ifdef SERIAL_SUB_OVF_EN
    n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b required 0", ovf); end
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;
    $display("reset: busy=%b done=%b diff=%h bout=%b", busy, done, diff, bout);
  endtask

  task automatic test_directed();
    logic [W-1:0] va [5];
    logic [W-1:0] vb [5];
    logic         vbin [5];
    logic [W:0]   e;
    int           cyc;
    va   = '{8'h05, 8'h03, 8'h00, 8'h80, 8'h7F};
    vb   = '{8'h03, 8'h05, 8'h00, 8'h01, 8'h01};
    vbin = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 5; k++) begin
      e = ref_sub(va[k], vb[k], vbin[k]);
      launch(va[k], vb[k], vbin[k]);
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL dir_busy[%0d]: got %b required 1", k, busy); end
      n_cmp++; if (diff !== last_diff) begin n_fail++; $display("FAIL dir_hold[%0d]: got %h required %h", k, diff, last_diff); end
      wait_done(cyc);
      n_cmp++; if (cyc !== W) begin n_fail++; $display("FAIL dir_latency[%0d]: got %0d required %0d", k, cyc, W); end
      n_cmp++; if (diff !== e[W-1:0]) begin n_fail++; $display("FAIL dir_diff[%0d]: got %h required %h", k, diff, e[W-1:0]); end
      n_cmp++; if (bout !== e[W]) begin n_fail++; $display("FAIL dir_bout[%0d]: got %b required %b", k, bout, e[W]); end
`ifdef SERIAL_SUB_OVF_EN
      n_cmp++; if (ovf !== ref_ovf(va[k], vb[k], e[W-1:0])) begin n_fail++; $display("FAIL dir_ovf[%0d]: got %b required %b", k, ovf, ref_ovf(va[k], vb[k], e[W-1:0])); end
`endif
      @(posedge clk);
      #1;
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL dir_pulse[%0d]: got %b required 0", k, done); end
      last_diff = e[W-1:0];
      $display("directed: a=%h b=%h bin=%b -> diff=%h bout=%b", va[k], vb[k], vbin[k], diff, bout);
    end
  endtask

  task automatic test_ignore_start();
    int cyc;
    launch(8'h05, 8'h03, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    a     = 8'hFF;
    b     = 8'h00;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ign_busy: got %b required 1", busy); end
    n_cmp++; if (diff !== last_diff) begin n_fail++; $display("FAIL ign_hold: got %h required %h", diff, last_diff); end
    wait_done(cyc);
    n_cmp++; if (cyc + 3 !== W) begin n_fail++; $display("FAIL ign_latency: got %0d required %0d", cyc + 3, W); end
    n_cmp++; if (diff !== 8'h02) begin n_fail++; $display("FAIL ign_diff: got %h required 02", diff); end
    n_cmp++; if (bout !== 1'b0) begin n_fail++; $display("FAIL ign_bout: got %b required 0", bout); end
    last_diff = 8'h02;
    @(posedge clk);
    #1;
    $display("ignore: a=05 b=03 with mid-run start -> diff=%h bout=%b", diff, bout);
  endtask

  task automatic test_back_to_back();
    logic [W:0] e1;
    logic [W:0] e2;
    int         cyc;
    e1 = ref_sub(8'h10, 8'h01, 1'b0);
    e2 = ref_sub(8'h20, 8'h30, 1'b1);
    launch(8'h10, 8'h01, 1'b0);
    wait_done(cyc);
    n_cmp++; if (diff !== e1[W-1:0]) begin n_fail++; $display("FAIL b2b_diff1: got %h required %h", diff, e1[W-1:0]); end
    launch(8'h20, 8'h30, 1'b1);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b required 1", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_done: got %b required 0", done); end
    n_cmp++; if (diff !== e1[W-1:0]) begin n_fail++; $display("FAIL b2b_hold: got %h required %h", diff, e1[W-1:0]); end
    wait_done(cyc);
    n_cmp++; if (cyc !== W) begin n_fail++; $display("FAIL b2b_latency: got %0d required %0d", cyc, W); end
    n_cmp++; if (diff !== e2[W-1:0]) begin n_fail++; $display("FAIL b2b_diff2: got %h required %h", diff, e2[W-1:0]); end
    n_cmp++; if (bout !== e2[W]) begin n_fail++; $display("FAIL b2b_bout2: got %b required %b", bout, e2[W]); end
    last_diff = e2[W-1:0];
    @(posedge clk);
    #1;
    $display("back_to_back: 10-01 then 20-30-1 -> diff=%h bout=%b", diff, bout);
  endtask

  task automatic test_reset_mid_run();
    logic [W:0] e;
    int         cyc;
    int         seen;
    launch(8'h55, 8'h22, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmr_busy: got %b required 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rmr_done: got %b required 0", done); end
    n_cmp++; if (diff !== '0) begin n_fail++; $display("FAIL rmr_diff: got %h required 00", diff); end
    n_cmp++; if (bout !== 1'b0) begin n_fail++; $display("FAIL rmr_bout: got %b required 0", bout); end
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 2 * W; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL rmr_activity: got %0d active cycles required 0", seen); end
    e = ref_sub(8'h09, 8'h04, 1'b1);
    launch(8'h09, 8'h04, 1'b1);
    wait_done(cyc);
    n_cmp++; if (cyc !== W) begin n_fail++; $display("FAIL rmr_latency: got %0d required %0d", cyc, W); end
    n_cmp++; if (diff !== e[W-1:0]) begin n_fail++; $display("FAIL rmr_diff2: got %h required %h", diff, e[W-1:0]); end
    last_diff = e[W-1:0];
    @(posedge clk);
    #1;
    $display("reset_mid_run: aborted, fresh 09-04-1 -> diff=%h bout=%b", diff, bout);
  endtask

  task automatic test_random();
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rbin;
    logic [W:0]   e;
    int           cyc;
    int           gap;
    for (int n = 0; n < 1000; n++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom_range(0, 1));
      e    = ref_sub(ra, rb, rbin);
      launch(ra, rb, rbin);
      n_cmp++; if (diff !== last_diff) begin n_fail++; $display("FAIL rnd_hold[%0d]: got %h required %h", n, diff, last_diff); end
      wait_done(cyc);
      n_cmp++; if (cyc !== W) begin n_fail++; $display("FAIL rnd_latency[%0d]: got %0d required %0d", n, cyc, W); end
      n_cmp++; if ({bout, diff} !== e) begin n_fail++; $display("FAIL rnd_result[%0d]: a=%h b=%h bin=%b got %h required %h", n, ra, rb, rbin, {bout, diff}, e); end
`ifdef SERIAL_SUB_OVF_EN
      n_cmp++; if (ovf !== ref_ovf(ra, rb, e[W-1:0])) begin n_fail++; $display("FAIL rnd_ovf[%0d]: got %b required %b", n, ovf, ref_ovf(ra, rb, e[W-1:0])); end
`endif
      $display("random %0d: a=%h b=%h bin=%b -> diff=%h bout=%b", n, ra, rb, rbin, diff, bout);
      last_diff = e[W-1:0];
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        @(posedge clk);
        #1;
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rnd_pulse[%0d]: got %b required 0", n, done); end
        repeat (gap - 1) @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
